cpu_controller: RTL



---
 rtl/cpu_controller_if.sv | 40 ++++
 rtl/cpu_controller.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/cpu_controller_if.sv
// Bus between cpu_controller and its driver: instruction/handshake inputs,
// datapath control outputs, and debug visibility of the FSM state and IR.
interface cpu_controller_if;
  // Handshake: load captures 'in' and s starts execution, both sampled on a
  // rising edge and acted on only while w = 1; w = 1 means idle and ready.
  logic [15:0] in;
  logic        load;
  logic        s;
  logic        w;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic        vsel;
  logic        write;
  logic [1:0]  ALUop;
  logic [1:0]  shift;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic [15:0] datapath_in;
  logic        illegal;
  logic [2:0]  dbg_state;
  logic [15:0] dbg_ir;

  modport master (
    output in, load, s,
    input  w, loada, loadb, loadc, loads, asel, bsel, vsel, write,
    input  ALUop, shift, readnum, writenum, datapath_in, illegal,
    input  dbg_state, dbg_ir
  );

  modport slave (
    input  in, load, s,
    output w, loada, loadb, loadc, loads, asel, bsel, vsel, write,
    output ALUop, shift, readnum, writenum, datapath_in, illegal,
    output dbg_state, dbg_ir
  );
endinterface

// File: rtl/cpu_controller.sv
// Instruction register plus Moore control FSM driving the datapath controls.
// Define CPU_CONTROLLER_ILLEGAL_TRAP_EN to trap illegal encodings in HALT.
module cpu_controller (
  input  logic            clk,
  input  logic            reset,
  cpu_controller_if.slave bus
);

  typedef enum logic [2:0] {
    ST_WAIT      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_WRITE_IMM = 3'd2,
    ST_GET_A     = 3'd3,
    ST_GET_B     = 3'd4,
    ST_COMPUTE   = 3'd5,
    ST_WRITE_REG = 3'd6
`ifdef CPU_CONTROLLER_ILLEGAL_TRAP_EN
    , ST_HALT    = 3'd7
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [2:0]  opcode;
  logic [1:0]  op;
  logic [2:0]  rn, rd, rm;
  logic [1:0]  sh;
  logic [15:0] sximm8;

  logic is_mov_imm, is_mov_reg, is_add, is_cmp, is_and, is_mvn;
  logic [1:0] alu_op;

  always_comb begin
    opcode = ir_q[15:13];
    op     = ir_q[12:11];
    rn     = ir_q[10:8];
    rd     = ir_q[7:5];
    sh     = ir_q[4:3];
    rm     = ir_q[2:0];
    sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
  end

  always_comb begin
    is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    is_add     = (opcode == 3'b101) && (op == 2'b00);
    is_cmp     = (opcode == 3'b101) && (op == 2'b01);
    is_and     = (opcode == 3'b101) && (op == 2'b10);
    is_mvn     = (opcode == 3'b101) && (op == 2'b11);
    // The ALU instructions carry their ALU operation in op; MOV-reg is a pass-through add.
    alu_op     = is_mov_reg ? 2'b00 : op;
  end

  // The IR only moves while idle, so fields stay stable across execution.
  always_comb begin
    ir_d = ir_q;
    if ((state_q == ST_WAIT) && bus.load) begin
      ir_d = bus.in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q <= 16'h0000;
    end else begin
      ir_q <= ir_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT: begin
        if (bus.s) begin
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_mov_imm) begin
          state_d = ST_WRITE_IMM;
        end else if (is_mov_reg || is_mvn) begin
          state_d = ST_GET_B;
        end else if (is_add || is_cmp || is_and) begin
          state_d = ST_GET_A;
        end else begin
`ifdef CPU_CONTROLLER_ILLEGAL_TRAP_EN
          state_d = ST_HALT;
`else
          state_d = ST_WAIT;
`endif
        end
      end
      ST_WRITE_IMM: state_d = ST_WAIT;
      ST_GET_A:     state_d = ST_GET_B;
      ST_GET_B:     state_d = ST_COMPUTE;
      ST_COMPUTE:   state_d = is_cmp ? ST_WAIT : ST_WRITE_REG;
      ST_WRITE_REG: state_d = ST_WAIT;
`ifdef CPU_CONTROLLER_ILLEGAL_TRAP_EN
      ST_HALT:      state_d = ST_HALT;
`endif
      default:      state_d = ST_WAIT;
    endcase
  end

  always_comb begin
    bus.w           = (state_q == ST_WAIT);
    bus.loada       = 1'b0;
    bus.loadb       = 1'b0;
    bus.loadc       = 1'b0;
    bus.loads       = 1'b0;
    bus.asel        = 1'b0;
    bus.bsel        = 1'b0;
    bus.vsel        = 1'b0;
    bus.write       = 1'b0;
    bus.ALUop       = 2'b00;
    bus.shift       = 2'b00;
    bus.readnum     = 3'd0;
    bus.writenum    = 3'd0;
    bus.datapath_in = {11'b0, ir_q[4:0]};
    bus.dbg_state   = state_q;
    bus.dbg_ir      = ir_q;
`ifdef CPU_CONTROLLER_ILLEGAL_TRAP_EN
    bus.illegal     = (state_q == ST_HALT);
`else
    bus.illegal     = 1'b0;
`endif
    case (state_q)
      ST_WRITE_IMM: begin
        bus.vsel        = 1'b1;
        bus.write       = 1'b1;
        bus.writenum    = rn;
        bus.datapath_in = sximm8;
      end
      ST_GET_A: begin
        bus.readnum = rn;
        bus.loada   = 1'b1;
      end
      ST_GET_B: begin
        bus.readnum = rm;
        bus.loadb   = 1'b1;
      end
      ST_COMPUTE: begin
        bus.shift = sh;
        bus.ALUop = alu_op;
        bus.asel  = is_mov_reg;
        bus.loads = is_cmp;
        bus.loadc = !is_cmp;
      end
      ST_WRITE_REG: begin
        bus.write    = 1'b1;
        bus.writenum = rd;
      end
      default: begin
      end
    endcase
  end

endmodule
